// File: rtl/dct_pkg.sv
// Shared definitions for the distributed-arithmetic DCT accumulator:
// FSM state encoding and the default word/beat sizes.
package dct_pkg;

  localparam int DCT_WIDTH   = 16;
  localparam int DCT_IN_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_t;

  // Beat-counter width; kept at least 1 bit so a single-beat build still elaborates.
  function automatic int dct_k_width(input int in_bits);
    return (in_bits > 1) ? $clog2(in_bits) : 1;
  endfunction

endpackage

// File: rtl/dct_da_acc_dp.sv
// Accumulate datapath: sign-extends p0+p1, shifts it by the beat index k and
// adds it to the accumulator (subtracts on the sign bit-plane, k = IN_BITS-1).
// The k = 0 beat overwrites the accumulator instead of adding to it.
module dct_da_acc_dp #(
  parameter int WIDTH   = 16,
  parameter int IN_BITS = 8,
  parameter int OUT_W   = WIDTH + IN_BITS + 2,
  parameter int K_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [K_W-1:0]   k,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  output logic [OUT_W-1:0] acc
);

  localparam logic [K_W-1:0] LAST_K = K_W'(IN_BITS - 1);

  logic [WIDTH:0]   pair;
  logic [OUT_W-1:0] pair_ext;
  logic [OUT_W-1:0] term;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] acc_next;

  // Pair sum is one bit wider than a ROM word so it never wraps before extension.
  assign pair     = {p0[WIDTH-1], p0} + {p1[WIDTH-1], p1};
  assign pair_ext = {{(OUT_W - WIDTH - 1){pair[WIDTH]}}, pair};
  assign term     = pair_ext << k;

  // Next accumulator value: start fresh on beat 0, negate the sign bit-plane.
  always_comb begin
    base     = (k == '0) ? '0 : acc;
    acc_next = (k == LAST_K) ? (base - term) : (base + term);
  end

  // Accumulator register; flush wins over a simultaneous beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/dct_da_acc_ctrl.sv
// Control for the DA accumulator: IDLE/ACCUM/DONE FSM, beat counter and the
// input/output handshakes. A beat transfers when in_valid && in_ready on a
// rising edge; a result transfers when out_valid && out_ready on a rising edge.
// out_valid holds with stable out_data until taken; no beat is accepted in DONE.
module dct_da_acc_ctrl
  import dct_pkg::*;
#(
  parameter int WIDTH   = DCT_WIDTH,
  parameter int IN_BITS = DCT_IN_BITS,
  parameter int OUT_W   = WIDTH + IN_BITS + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  localparam int             K_W    = dct_k_width(IN_BITS);
  localparam logic [K_W-1:0] LAST_K = K_W'(IN_BITS - 1);

  dct_state_t     state;
  logic [K_W-1:0] k;
  logic           accept;

  // Ready in IDLE/ACCUM only, and forced low while reset is held.
  assign in_ready = rst_n && (state != ST_DONE);
  assign accept   = in_valid && in_ready;

  // FSM, beat counter and registered status outputs; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (IN_BITS == 1) begin
              state     <= ST_DONE;
              k         <= '0;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACCUM;
              k     <= k + K_W'(1);
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (k == LAST_K) begin
              state     <= ST_DONE;
              k         <= '0;
              out_valid <= 1'b1;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          k         <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  dct_da_acc_dp #(
    .WIDTH   (WIDTH),
    .IN_BITS (IN_BITS),
    .OUT_W   (OUT_W),
    .K_W     (K_W)
  ) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (accept),
    .k     (k),
    .p0    (p0),
    .p1    (p1),
    .acc   (out_data)
  );

endmodule
